// File: rtl/conv_window_scheduler_if.sv
// Handshake and address bus between the convolution window scheduler,
// the layer controller, the MAC datapath and the downstream result writer.
interface conv_window_scheduler_if #(
    parameter int ADDR_W    = 16,
    parameter int WIDTH_BIT = 8
);
    logic                 start;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 acc_clr;
    logic                 mac_en;
    logic [ADDR_W-1:0]    in_addr;
    logic [ADDR_W-1:0]    k_addr;
    logic                 out_valid;
    logic [WIDTH_BIT-1:0] out_row;
    logic [WIDTH_BIT-1:0] out_col;

    modport master (
        input  start,
        input  out_ready,
        output busy,
        output done,
        output acc_clr,
        output mac_en,
        output in_addr,
        output k_addr,
        output out_valid,
        output out_row,
        output out_col
    );

    modport slave (
        output start,
        output out_ready,
        input  busy,
        input  done,
        input  acc_clr,
        input  mac_en,
        input  in_addr,
        input  k_addr,
        input  out_valid,
        input  out_row,
        input  out_col
    );
endinterface

// File: rtl/conv_window_scheduler.sv
// Walks every output window and kernel tap of one convolution pass, issuing
// memory addresses and MAC strobes, then hands each window to the writer.
module conv_window_scheduler #(
    parameter int IMG_ROWS  = 4,
    parameter int IMG_COLS  = 4,
    parameter int K_SIZE    = 3,
    parameter int STRIDE    = 1,
    parameter int WIDTH_BIT = 8,
    parameter int ADDR_W    = 16
) (
    input  logic                    clock,
    input  logic                    nreset,
    conv_window_scheduler_if.master bus
);
    localparam logic [31:0] OUT_R    = 32'((IMG_ROWS - K_SIZE) / STRIDE + 1);
    localparam logic [31:0] OUT_C    = 32'((IMG_COLS - K_SIZE) / STRIDE + 1);
    localparam logic [31:0] K_LAST   = 32'(K_SIZE - 1);
    localparam logic [63:0] STRIDE_W = 64'(STRIDE);
    localparam logic [63:0] COLS_W   = 64'(IMG_COLS);
    localparam logic [63:0] KSIZE_W  = 64'(K_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        EMIT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] r;
    logic [31:0] c;
    logic [31:0] ki;
    logic [31:0] kj;

    // Addresses are formed at 64 bits and only narrowed when registered.
    function automatic logic [ADDR_W-1:0] feat_addr(input logic [31:0] rr, input logic [31:0] cc,
                                                    input logic [31:0] ii, input logic [31:0] jj);
        logic [63:0] full;
        full = ((64'(rr) * STRIDE_W) + 64'(ii)) * COLS_W + (64'(cc) * STRIDE_W) + 64'(jj);
        return ADDR_W'(full);
    endfunction

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [31:0] ii, input logic [31:0] jj);
        logic [63:0] full;
        full = 64'(ii) * KSIZE_W + 64'(jj);
        return ADDR_W'(full);
    endfunction

    // Every output is computed for the state being entered, so all strobes,
    // addresses and positions come straight from flops.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state         <= IDLE;
            r             <= '0;
            c             <= '0;
            ki            <= '0;
            kj            <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.acc_clr   <= 1'b0;
            bus.mac_en    <= 1'b0;
            bus.in_addr   <= '0;
            bus.k_addr    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= CLEAR;
                        r           <= '0;
                        c           <= '0;
                        ki          <= '0;
                        kj          <= '0;
                        bus.busy    <= 1'b1;
                        bus.acc_clr <= 1'b1;
                    end
                end

                CLEAR: begin
                    state       <= MAC;
                    ki          <= '0;
                    kj          <= '0;
                    bus.acc_clr <= 1'b0;
                    bus.mac_en  <= 1'b1;
                    bus.in_addr <= feat_addr(r, c, 32'd0, 32'd0);
                    bus.k_addr  <= tap_addr(32'd0, 32'd0);
                end

                // Taps run row-major through the kernel; the last tap hands over to EMIT.
                MAC: begin
                    if (kj == K_LAST) begin
                        if (ki == K_LAST) begin
                            state         <= EMIT;
                            bus.mac_en    <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_row   <= WIDTH_BIT'(r);
                            bus.out_col   <= WIDTH_BIT'(c);
                        end else begin
                            ki          <= ki + 32'd1;
                            kj          <= '0;
                            bus.in_addr <= feat_addr(r, c, ki + 32'd1, 32'd0);
                            bus.k_addr  <= tap_addr(ki + 32'd1, 32'd0);
                        end
                    end else begin
                        kj          <= kj + 32'd1;
                        bus.in_addr <= feat_addr(r, c, ki, kj + 32'd1);
                        bus.k_addr  <= tap_addr(ki, kj + 32'd1);
                    end
                end

                // Everything holds while the writer stalls.
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if ((r == OUT_R - 32'd1) && (c == OUT_C - 32'd1)) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state       <= CLEAR;
                            bus.acc_clr <= 1'b1;
                            if (c == OUT_C - 32'd1) begin
                                c <= '0;
                                r <= r + 32'd1;
                            end else begin
                                c <= c + 32'd1;
                            end
                        end
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    r        <= '0;
                    c        <= '0;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b0;
                    bus.acc_clr   <= 1'b0;
                    bus.mac_en    <= 1'b0;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Lockstep bench for conv_window_scheduler over three map/kernel shapes,
// predicting each cycle from the window/tap enumeration of a convolution pass.
module tb_conv_window_scheduler;
    logic clock = 1'b0;
    logic nreset;
    int   total = 0;
    int   bad = 0;
    int   cur = 0;
    int   win = 0;
    int   busyCnt = 0;
    int   doneCnt = 0;
    string ctx = "reset";

    always #5 clock = ~clock;

    conv_window_scheduler_if #(.ADDR_W(16), .WIDTH_BIT(8)) bus0 ();
    conv_window_scheduler_if #(.ADDR_W(16), .WIDTH_BIT(8)) bus1 ();
    conv_window_scheduler_if #(.ADDR_W(16), .WIDTH_BIT(8)) bus2 ();

    conv_window_scheduler #(.IMG_ROWS(4), .IMG_COLS(4), .K_SIZE(3), .STRIDE(1), .WIDTH_BIT(8), .ADDR_W(16))
        dut0 (.clock(clock), .nreset(nreset), .bus(bus0.master));
    conv_window_scheduler #(.IMG_ROWS(5), .IMG_COLS(5), .K_SIZE(3), .STRIDE(2), .WIDTH_BIT(8), .ADDR_W(16))
        dut1 (.clock(clock), .nreset(nreset), .bus(bus1.master));
    conv_window_scheduler #(.IMG_ROWS(2), .IMG_COLS(2), .K_SIZE(1), .STRIDE(1), .WIDTH_BIT(8), .ADDR_W(16))
        dut2 (.clock(clock), .nreset(nreset), .bus(bus2.master));

    logic        oBusy, oDone, oClr, oMac, oValid;
    logic [15:0] oIn, oK;
    logic [7:0]  oRow, oCol;

    // Route the scheduler under test onto one set of observation signals.
    always_comb begin
        oBusy = bus0.busy; oDone = bus0.done; oClr = bus0.acc_clr; oMac = bus0.mac_en;
        oValid = bus0.out_valid; oIn = bus0.in_addr; oK = bus0.k_addr;
        oRow = bus0.out_row; oCol = bus0.out_col;
        if (cur == 1) begin
            oBusy = bus1.busy; oDone = bus1.done; oClr = bus1.acc_clr; oMac = bus1.mac_en;
            oValid = bus1.out_valid; oIn = bus1.in_addr; oK = bus1.k_addr;
            oRow = bus1.out_row; oCol = bus1.out_col;
        end else if (cur == 2) begin
            oBusy = bus2.busy; oDone = bus2.done; oClr = bus2.acc_clr; oMac = bus2.mac_en;
            oValid = bus2.out_valid; oIn = bus2.in_addr; oK = bus2.k_addr;
            oRow = bus2.out_row; oCol = bus2.out_col;
        end
    end

    task automatic applyStimulus(input logic st, input logic rdy);
        bus0.start = (cur == 0) ? st : 1'b0;
        bus0.out_ready = (cur == 0) ? rdy : 1'b0;
        bus1.start = (cur == 1) ? st : 1'b0;
        bus1.out_ready = (cur == 1) ? rdy : 1'b0;
        bus2.start = (cur == 2) ? st : 1'b0;
        bus2.out_ready = (cur == 2) ? rdy : 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s (dut%0d %s) observed=%0d expected=%0d", tag, cur, ctx, obs, exp);
        end
    endtask

    task automatic checkCycle(input logic b, input logic d, input logic clr, input logic mac,
                              input logic v, input bit chkAddr, input int ia, input int ka,
                              input bit chkPos, input int row, input int col);
        if (oBusy === 1'b1) busyCnt++;
        if (oDone === 1'b1) doneCnt++;
        checkOutput("busy", 32'(oBusy), 32'(b));
        checkOutput("done", 32'(oDone), 32'(d));
        checkOutput("acc_clr", 32'(oClr), 32'(clr));
        checkOutput("mac_en", 32'(oMac), 32'(mac));
        checkOutput("out_valid", 32'(oValid), 32'(v));
        if (chkAddr) begin
            checkOutput("in_addr", 32'(oIn), 32'(ia));
            checkOutput("k_addr", 32'(oK), 32'(ka));
        end
        if (chkPos) begin
            checkOutput("out_row", 32'(oRow), 32'(row));
            checkOutput("out_col", 32'(oCol), 32'(col));
        end
    endtask

    function automatic logic randBit(input bit enable);
        return enable ? logic'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // One pass from the reference enumeration: windows row-major, taps row-major,
    // optional stalls in EMIT, optional reset dropped into the MAC of one window.
    task automatic runPass(input int rows, input int cols, input int k, input int s,
                           input int firstStall, input int abortWin, input bit noisy);
        int outR;
        int outC;
        int stalls;
        int n;
        outR = (rows - k) / s + 1;
        outC = (cols - k) / s + 1;
        stalls = 0;
        busyCnt = 0;
        doneCnt = 0;
        win = 0;
        @(negedge clock);
        applyStimulus(1'b1, 1'b0);
        @(negedge clock);
        for (int r = 0; r < outR; r++) begin
            for (int c = 0; c < outC; c++) begin
                ctx = $sformatf("win%0d clear", win);
                checkCycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
                applyStimulus(randBit(noisy), randBit(noisy));
                for (int ki = 0; ki < k; ki++) begin
                    for (int kj = 0; kj < k; kj++) begin
                        @(negedge clock);
                        ctx = $sformatf("win%0d tap%0d,%0d", win, ki, kj);
                        checkCycle(1, 0, 0, 1, 0, 1, (r * s + ki) * cols + (c * s + kj), ki * k + kj, 0, 0, 0);
                        applyStimulus(randBit(noisy), randBit(noisy));
                        if (win == abortWin && ki == 0 && kj == 1) begin
                            nreset = 1'b0;
                            applyStimulus(1'b0, 1'b0);
                            @(negedge clock);
                            ctx = "abort";
                            checkCycle(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
                            nreset = 1'b1;
                            @(negedge clock);
                            ctx = "after abort";
                            checkCycle(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
                            return;
                        end
                    end
                end
                @(negedge clock);
                if (win == 0 && firstStall >= 0) n = firstStall;
                else n = noisy ? int'($urandom_range(0, 3)) : 0;
                stalls += n;
                for (int i = 0; i <= n; i++) begin
                    if (i > 0) @(negedge clock);
                    ctx = $sformatf("win%0d emit%0d", win, i);
                    checkCycle(1, 0, 0, 0, 1, 0, 0, 0, 1, r, c);
                    applyStimulus(randBit(noisy), (i == n) ? 1'b1 : 1'b0);
                end
                @(negedge clock);
                win++;
            end
        end
        ctx = "done";
        checkCycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0);
        @(negedge clock);
        ctx = "idle";
        checkCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("busy_cycles", 32'(busyCnt), 32'(outR * outC * (k * k + 2) + 1 + stalls));
        checkOutput("done_pulses", 32'(doneCnt), 32'd1);
    endtask

    initial begin
        nreset = 1'b0;
        cur = 0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            cur = i;
            #1;
            ctx = "reset";
            checkCycle(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        end
        cur = 0;
        applyStimulus(1'b0, 1'b0);
        @(negedge clock);
        nreset = 1'b1;

        $display("[TB] 4x4 K=3 S=1 plain pass");
        runPass(4, 4, 3, 1, 0, -1, 0);
        $display("[TB] 4x4 backpressure of 3 cycles in first window");
        runPass(4, 4, 3, 1, 3, -1, 0);
        $display("[TB] 4x4 with stray start/out_ready and random stalls");
        runPass(4, 4, 3, 1, -1, -1, 1);
        $display("[TB] 4x4 reset during MAC of window (0,1), then restart");
        runPass(4, 4, 3, 1, 0, 1, 1);
        runPass(4, 4, 3, 1, 0, -1, 0);

        cur = 1;
        applyStimulus(1'b0, 1'b0);
        $display("[TB] 5x5 K=3 S=2");
        runPass(5, 5, 3, 2, 0, -1, 0);
        runPass(5, 5, 3, 2, -1, -1, 1);

        cur = 2;
        applyStimulus(1'b0, 1'b0);
        $display("[TB] 2x2 K=1");
        runPass(2, 2, 1, 1, 0, -1, 0);
        runPass(2, 2, 1, 1, -1, -1, 1);

        for (int p = 0; p < 6; p++) begin
            cur = p % 3;
            applyStimulus(1'b0, 1'b0);
            if (cur == 0) runPass(4, 4, 3, 1, -1, -1, 1);
            else if (cur == 1) runPass(5, 5, 3, 2, -1, -1, 1);
            else runPass(2, 2, 1, 1, -1, -1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
